// File: rtl/blur_pkg.sv
// Shared definitions for the blur output path: image geometry, pixel type and
// the stream-reader state encoding.
package blur_pkg;

  localparam int IMG_W       = 640;
  localparam int IMG_H       = 480;
  localparam int BLUR_BORDER = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } reader_state_t;

endpackage

// File: rtl/blur_skid_fifo.sv
// Two-entry skid FIFO between the buffer read pipeline and the output stream.
// Each entry carries a pixel plus a flag marking it as a border-fill position.
module blur_skid_fifo
  import blur_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  rgb_t       i_pushData,
  input  logic       i_pushFill,
  input  logic       i_pop,
  output rgb_t       o_headData,
  output logic       o_headFill,
  output logic [1:0] o_count
);

  rgb_t       r_data [2];
  logic [1:0] r_fill;
  logic       r_rdPtr;
  logic       r_wrPtr;
  logic [1:0] r_count;

  // The caller never pushes into a full FIFO or pops an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_fill    <= '0;
      r_rdPtr   <= 1'b0;
      r_wrPtr   <= 1'b0;
      r_count   <= '0;
    end else begin
      if (i_push) begin
        r_data[r_wrPtr] <= i_pushData;
        r_fill[r_wrPtr] <= i_pushFill;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (i_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_headData = r_data[r_rdPtr];
  assign o_headFill = r_fill[r_rdPtr];
  assign o_count    = r_count;

endmodule

// File: rtl/blur_stream_reader.sv
// Drains the blur output buffers into a valid/ready pixel stream with frame markers.
// Optional border fill is enabled by defining BLUR_READER_BORDER_FILL_EN.
module blur_stream_reader
  import blur_pkg::*;
#(
  parameter int   OUT_W    = IMG_W - 2 * BLUR_BORDER,
  parameter int   OUT_H    = IMG_H - 2 * BLUR_BORDER,
  parameter int   BORDER   = BLUR_BORDER,
  parameter rgb_t FILL_RGB = 24'h000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src_avail,
  input  rgb_t       src_rgb,
  output logic       rd_en,
  output logic       out_valid,
  input  logic       out_ready,
  output rgb_t       out_rgb,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic [9:0] out_x,
  output logic [8:0] out_y,
  output logic       frame_done
);

`ifdef BLUR_READER_BORDER_FILL_EN
  localparam int FRAME_W = OUT_W + 2 * BORDER;
  localparam int FRAME_H = OUT_H + 2 * BORDER;
`else
  localparam int FRAME_W = OUT_W;
  localparam int FRAME_H = OUT_H;
`endif

  localparam logic [9:0] LAST_X = 10'(FRAME_W - 1);
  localparam logic [8:0] LAST_Y = 9'(FRAME_H - 1);

  reader_state_t r_state;
  reader_state_t w_nextState;

  logic [9:0] r_x;
  logic [8:0] r_y;
  logic [9:0] r_ix;
  logic [8:0] r_iy;
  logic       r_issueDone;
  logic       r_inflight;
  logic       r_inflightFill;

  rgb_t       w_headData;
  logic       w_headFill;
  logic [1:0] w_count;
  logic       w_transfer;
  logic       w_headEol;
  logic       w_headEof;
  logic [2:0] w_occNext;
  logic       w_credit;
  logic       w_border;
  logic       w_canIssue;

  blur_skid_fifo u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_pushData (src_rgb),
    .i_pushFill (r_inflightFill),
    .i_pop      (w_transfer),
    .o_headData (w_headData),
    .o_headFill (w_headFill),
    .o_count    (w_count)
  );

  assign out_valid  = (w_count != 2'd0);
  assign w_transfer = out_valid && out_ready;
  assign w_headEol  = (r_x == LAST_X);
  assign w_headEof  = w_headEol && (r_y == LAST_Y);

  // Occupancy is counted after this cycle's pop so a draining FIFO keeps 1 pixel/cycle.
  assign w_occNext = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_transfer};
  assign w_credit  = (w_occNext < 3'd2);

`ifdef BLUR_READER_BORDER_FILL_EN
  assign w_border = (r_ix < 10'(BORDER)) || (r_ix >= 10'(OUT_W + BORDER)) ||
                    (r_iy < 9'(BORDER))  || (r_iy >= 9'(OUT_H + BORDER));
`else
  assign w_border = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (src_avail) w_nextState = STREAM;
      STREAM:  if (w_transfer && w_headEof) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_canIssue = 1'b0;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      STREAM: begin
        w_canIssue = !r_issueDone && w_credit && (w_border || src_avail);
        rd_en      = w_canIssue && !w_border;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // Issue-side position: which frame position the next read or fill belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ix           <= '0;
      r_iy           <= '0;
      r_issueDone    <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflightFill <= 1'b0;
    end else begin
      r_inflight     <= w_canIssue;
      r_inflightFill <= w_canIssue && w_border;
      if (r_state == DONE) begin
        r_ix        <= '0;
        r_iy        <= '0;
        r_issueDone <= 1'b0;
      end else if (w_canIssue) begin
        if (r_ix == LAST_X) begin
          r_ix <= '0;
          if (r_iy == LAST_Y) begin
            r_iy        <= '0;
            r_issueDone <= 1'b1;
          end else begin
            r_iy <= r_iy + 9'd1;
          end
        end else begin
          r_ix <= r_ix + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == DONE) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_transfer) begin
      if (w_headEol) begin
        r_x <= '0;
        r_y <= w_headEof ? 9'd0 : r_y + 9'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  assign out_rgb = w_headFill ? FILL_RGB : w_headData;
  assign out_sof = out_valid && (r_x == 10'd0) && (r_y == 9'd0);
  assign out_eol = out_valid && w_headEol;
  assign out_eof = out_valid && w_headEof;
  assign out_x   = r_x;
  assign out_y   = r_y;

endmodule

// File: tb/tb_blur_stream_reader.sv
// Self-checking bench for blur_stream_reader on a small frame; covers the
// default build and, when BLUR_READER_BORDER_FILL_EN is defined, border fill.
module tb_blur_stream_reader;
  import blur_pkg::*;

  localparam int          W    = 8;
  localparam int          H    = 4;
  localparam int          B    = 2;
  localparam logic [23:0] FILL = 24'h123456;
`ifdef BLUR_READER_BORDER_FILL_EN
  localparam int EB = B;
`else
  localparam int EB = 0;
`endif
  localparam int FW = W + 2 * EB;
  localparam int FH = H + 2 * EB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_avail;
  logic [23:0] src_rgb = '0;
  logic        rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic        frame_done;

  always #5 clk = ~clk;

  blur_stream_reader #(
    .OUT_W    (W),
    .OUT_H    (H),
    .BORDER   (B),
    .FILL_RGB (FILL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_avail  (src_avail),
    .src_rgb    (src_rgb),
    .rd_en      (rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rgb    (out_rgb),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Buffer model: ramp data, returned one cycle after rd_en; each read is queued as expected output.
  int          srcPtr  = 0;
  int          readCnt = 0;
  logic [23:0] readQ[$];

  always @(posedge clk) begin
    if (rst_n && rd_en) begin
      src_rgb <= 24'(srcPtr);
      readQ.push_back(24'(srcPtr));
      srcPtr++;
      readCnt++;
    end
  end

  // Output monitor and scoreboard.
  int          ex = 0, ey = 0;
  int          xferCnt = 0, doneCnt = 0;
  bit          eofSeen = 0, pendingDone = 0, prevStall = 0;
  logic [23:0] prevRgb;
  logic [2:0]  prevMarks;
  int          mCount = 0;
  int          mInflight = 0;

  always @(negedge clk) begin
    logic [23:0] expRgb;
    bit          isBorder, expSof, expEol, expEof;
    int          occNext;
    if (!rst_n) begin
      ex = 0; ey = 0; pendingDone = 0; prevStall = 0; mCount = 0; mInflight = 0;
      readQ.delete();
    end else begin
      if (pendingDone) begin
        checkOutput("frame_done after eof", 32'(frame_done), 32'd1);
        pendingDone = 0;
      end else if (frame_done) begin
        checkOutput("spurious frame_done", 32'(frame_done), 32'd0);
      end
      if (frame_done) doneCnt++;

      if (prevStall) begin
        checkOutput("valid held under stall", 32'(out_valid), 32'd1);
        checkOutput("rgb held under stall", 32'(out_rgb), 32'(prevRgb));
        checkOutput("markers held under stall", 32'({out_sof, out_eol, out_eof}), 32'(prevMarks));
      end

      if (out_valid && out_ready) begin
        isBorder = (ex < EB) || (ex >= W + EB) || (ey < EB) || (ey >= H + EB);
        expRgb   = FILL;
        if (!isBorder) begin
          if (readQ.size() == 0) begin
            checkOutput("read queue has data", 32'(readQ.size()), 32'd1);
            expRgb = 'x;
          end else begin
            expRgb = readQ.pop_front();
          end
        end
        expSof = (ex == 0) && (ey == 0);
        expEol = (ex == FW - 1);
        expEof = expEol && (ey == FH - 1);
        checkOutput("pixel rgb+markers", {5'b0, out_rgb, out_sof, out_eol, out_eof},
                    {5'b0, expRgb, expSof, expEol, expEof});
        checkOutput("pixel x/y", {13'b0, out_x, out_y}, {13'b0, 10'(ex), 9'(ey)});
        if (expEol) begin
          ex = 0;
          ey = expEof ? 0 : ey + 1;
        end else begin
          ex++;
        end
        if (expEof) begin
          pendingDone = 1;
          eofSeen     = 1;
        end
        xferCnt++;
      end

      prevStall = out_valid && !out_ready;
      prevRgb   = out_rgb;
      prevMarks = {out_sof, out_eol, out_eof};

`ifndef BLUR_READER_BORDER_FILL_EN
      occNext = mCount + mInflight - ((out_valid && out_ready) ? 1 : 0);
      if (rd_en) checkOutput("rd_en within credit", 32'(occNext + 1 <= 2), 32'd1);
      mCount    = occNext;
      mInflight = rd_en ? 1 : 0;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic avail, input logic ready);
    src_avail = avail;
    out_ready = ready;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " rd_en"}, 32'(rd_en), 32'd0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " out_rgb"}, 32'(out_rgb), 32'd0);
    checkOutput({tag, " markers"}, 32'({out_sof, out_eol, out_eof}), 32'd0);
    checkOutput({tag, " x/y"}, {13'b0, out_x, out_y}, 32'd0);
    checkOutput({tag, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic startFrame();
    readCnt = 0; xferCnt = 0; doneCnt = 0; eofSeen = 0;
  endtask

  task automatic finishFrame(input logic [3:0] aMask, input logic [3:0] rMask,
                             input int expXfers, input int expReads, input int maxCycles);
    int cyc;
    cyc = 0;
    while (!eofSeen && cyc < 3000) begin
      applyStimulus(aMask[cyc % 4], rMask[cyc % 4]);
      tick();
      cyc++;
    end
    checkOutput("frame completes", 32'(eofSeen), 32'd1);
    checkOutput("frame cycle budget", 32'(cyc <= maxCycles), 32'd1);
    applyStimulus(1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("transfers per frame", 32'(xferCnt), 32'(expXfers));
    checkOutput("reads per frame", 32'(readCnt), 32'(expReads));
    checkOutput("frame_done pulses", 32'(doneCnt), 32'd1);
    checkOutput("read queue drained", 32'(readQ.size()), 32'd0);
  endtask

  typedef struct {
    logic [3:0] availMask;
    logic [3:0] readyMask;
    int         expXfers;
    int         expReads;
    int         maxCycles;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{4'b1111, 4'b1111, FW * FH, W * H, FW * FH + 4};
    vecs[1] = '{4'b1111, 4'b1001, FW * FH, W * H, 3000};
    vecs[2] = '{4'b0101, 4'b1111, FW * FH, W * H, 3000};
    vecs[3] = '{4'b0111, 4'b1101, FW * FH, W * H, 3000};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Latency from src_avail through IDLE->STREAM to the first valid pixel.
    startFrame();
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("rd_en low in IDLE", 32'(rd_en), 32'd0);
    tick();
`ifndef BLUR_READER_BORDER_FILL_EN
    checkOutput("rd_en first STREAM cycle", 32'(rd_en), 32'd1);
`endif
    checkOutput("valid latency 1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("valid latency 2", 32'(out_valid), 32'd0);
    tick();
    checkOutput("valid latency 3", 32'(out_valid), 32'd1);
    checkOutput("first pixel sof", 32'(out_sof), 32'd1);
    finishFrame(4'b1111, 4'b1111, FW * FH, W * H, 3000);

    for (int i = 0; i < 4; i++) begin
      startFrame();
      finishFrame(vecs[i].availMask, vecs[i].readyMask, vecs[i].expXfers,
                  vecs[i].expReads, vecs[i].maxCycles);
    end

    // Source starvation after the fifth buffer read.
    startFrame();
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (readCnt < 5 && n < 500) begin
      tick();
      n++;
    end
    applyStimulus(1'b0, 1'b1);
    repeat (5) tick();
    checkOutput("starved valid low", 32'(out_valid), 32'd0);
    checkOutput("starved x frozen", 32'(out_x), 32'(5 + EB));
    checkOutput("starved reads frozen", 32'(readCnt), 32'd5);
    finishFrame(4'b1111, 4'b1111, FW * FH, W * H, 3000);

    // Reset in the middle of line 2, then a clean frame.
    startFrame();
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (!(out_valid && out_y == 9'd2) && n < 500) begin
      tick();
      n++;
    end
    checkOutput("reached line 2", 32'(out_y), 32'd2);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid-frame reset");
    repeat (2) tick();
    rst_n = 1'b1;
    startFrame();
    finishFrame(4'b1111, 4'b1111, FW * FH, W * H, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
